day5_input_parser: RTL and testbench

DAY5_INPUT_PARSER -- requirements
Module: day5_input_parser

---
 rtl/day5_pkg.sv | 20 ++
 rtl/decimal_accumulator.sv | 30 +++
 rtl/sat_counter.sv | 23 ++
 rtl/day5_input_parser.sv | 207 ++++++++++++++++++++
 tb/tb_day5_input_parser.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/day5_pkg.sv
// Shared types and constants for the day-5 puzzle input parser.
package day5_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_9    = 8'h39;
    localparam logic [7:0] CHAR_DASH = 8'h2D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_CR   = 8'h0D;

    typedef enum logic [2:0] {
        RANGE_LO,
        RANGE_HI,
        IDS,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal digit accumulator: acc <= acc*10 + digit, wrapping modulo 2^WIDTH.
module decimal_accumulator #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [3:0]       i_digit,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_acc_next
);

    logic [WIDTH-1:0] r_acc;

    // Multiply by ten with shifts only; the final digit may be consumed before it is registered.
    assign o_acc_next = (r_acc << 3) + (r_acc << 1) + {{(WIDTH - 4){1'b0}}, i_digit};
    assign o_acc      = r_acc;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/day5_input_parser.sv
// Streams puzzle text bytes and emits "lo-hi" ranges, then IDs after the blank separator line.
module day5_input_parser
    import day5_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             load_ranges,
    output logic [WIDTH-1:0] start_range,
    output logic [WIDTH-1:0] end_range,
    output logic             id_valid,
    output logic [WIDTH-1:0] id,
    output logic             start_transfer,
    output logic [15:0]      range_count,
    output logic [31:0]      id_count,
    output logic             done,
    output logic             error
);

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_lo, w_lo_d;
    logic             r_seen, w_seen_d;
    logic             r_load, w_load_d;
    logic [WIDTH-1:0] r_start, w_start_d;
    logic [WIDTH-1:0] r_end, w_end_d;
    logic             r_idv, w_idv_d;
    logic [WIDTH-1:0] r_id, w_id_d;
    logic             r_start_tr, w_start_tr_d;
    logic             r_done, w_done_d;
    logic             r_error, w_error_d;

    logic             w_accept;
    logic             w_is_digit;
    logic             w_acc_clear;
    logic             w_acc_en;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign in_ready   = (r_state != DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_is_digit = (in_data >= CHAR_0) && (in_data <= CHAR_9);

    decimal_accumulator #(
        .WIDTH (WIDTH)
    ) u_acc (
        .i_clock    (clock),
        .i_reset_n  (reset),
        .i_clear    (w_acc_clear),
        .i_enable   (w_acc_en),
        .i_digit    (in_data[3:0]),
        .o_acc      (w_acc),
        .o_acc_next (w_acc_next)
    );

    always_comb begin
        w_state_d    = r_state;
        w_lo_d       = r_lo;
        w_seen_d     = r_seen;
        w_load_d     = 1'b0;
        w_start_d    = r_start;
        w_end_d      = r_end;
        w_idv_d      = 1'b0;
        w_id_d       = r_id;
        w_start_tr_d = r_start_tr;
        w_acc_clear  = 1'b0;
        w_acc_en     = 1'b0;

        if (w_accept) begin
            unique case (r_state)
                RANGE_LO: begin
                    if (in_last) begin
                        w_state_d = ERR;
                    end else if (w_is_digit) begin
                        w_acc_en = 1'b1;
                        w_seen_d = 1'b1;
                    end else if (in_data == CHAR_CR) begin
                        w_state_d = r_state;
                    end else if ((in_data == CHAR_DASH) && r_seen) begin
                        w_lo_d      = w_acc;
                        w_acc_clear = 1'b1;
                        w_seen_d    = 1'b0;
                        w_state_d   = RANGE_HI;
                    end else if ((in_data == CHAR_LF) && !r_seen) begin
                        w_start_tr_d = 1'b1;
                        w_state_d    = IDS;
                    end else begin
                        w_state_d = ERR;
                    end
                end
                RANGE_HI: begin
                    if (in_last) begin
                        w_state_d = ERR;
                    end else if (w_is_digit) begin
                        w_acc_en = 1'b1;
                        w_seen_d = 1'b1;
                    end else if (in_data == CHAR_CR) begin
                        w_state_d = r_state;
                    end else if ((in_data == CHAR_LF) && r_seen) begin
                        if (r_lo > w_acc) begin
                            w_state_d = ERR;
                        end else begin
                            w_load_d    = 1'b1;
                            w_start_d   = r_lo;
                            w_end_d     = w_acc;
                            w_acc_clear = 1'b1;
                            w_seen_d    = 1'b0;
                            w_state_d   = RANGE_LO;
                        end
                    end else begin
                        w_state_d = ERR;
                    end
                end
                IDS: begin
                    if (w_is_digit) begin
                        w_acc_en = 1'b1;
                        w_seen_d = 1'b1;
                        // A digit on the last byte completes the ID without a trailing newline.
                        if (in_last) begin
                            w_idv_d   = 1'b1;
                            w_id_d    = w_acc_next;
                            w_state_d = DONE;
                        end
                    end else if ((in_data == CHAR_CR) || (in_data == CHAR_LF)) begin
                        if (r_seen && ((in_data == CHAR_LF) || in_last)) begin
                            w_idv_d     = 1'b1;
                            w_id_d      = w_acc;
                            w_acc_clear = 1'b1;
                            w_seen_d    = 1'b0;
                        end
                        if (in_last) begin
                            w_state_d = DONE;
                        end
                    end else begin
                        w_state_d = ERR;
                    end
                end
                default: begin
                    w_state_d = r_state;
                end
            endcase
        end

        w_done_d  = r_done || (w_state_d == DONE);
        w_error_d = r_error || (w_state_d == ERR);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= RANGE_LO;
            r_lo       <= '0;
            r_seen     <= 1'b0;
            r_load     <= 1'b0;
            r_start    <= '0;
            r_end      <= '0;
            r_idv      <= 1'b0;
            r_id       <= '0;
            r_start_tr <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_lo       <= w_lo_d;
            r_seen     <= w_seen_d;
            r_load     <= w_load_d;
            r_start    <= w_start_d;
            r_end      <= w_end_d;
            r_idv      <= w_idv_d;
            r_id       <= w_id_d;
            r_start_tr <= w_start_tr_d;
            r_done     <= w_done_d;
            r_error    <= w_error_d;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_range_count (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_inc     (r_load),
        .o_count   (range_count)
    );

    sat_counter #(
        .WIDTH (32)
    ) u_id_count (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_inc     (r_idv),
        .o_count   (id_count)
    );

    assign load_ranges    = r_load;
    assign start_range    = r_start;
    assign end_range      = r_end;
    assign id_valid       = r_idv;
    assign id             = r_id;
    assign start_transfer = r_start_tr;
    assign done           = r_done;
    assign error          = r_error;

endmodule

// File: tb/tb_day5_input_parser.sv
// Scoreboard bench for day5_input_parser: directed text streams, queued expected pulses.
module tb_day5_input_parser;

    typedef struct {
        bit          is_range;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        load_ranges;
    logic [63:0] start_range;
    logic [63:0] end_range;
    logic        id_valid;
    logic [63:0] id;
    logic        start_transfer;
    logic [15:0] range_count;
    logic [31:0] id_count;
    logic        done;
    logic        error;

    logic [7:0]  in_data8;
    logic        in_valid8;
    logic        in_last8;
    logic        in_ready8;
    logic        load8;
    logic [7:0]  start8;
    logic [7:0]  end8;
    logic        idv8;
    logic [7:0]  id8;
    logic        st8;
    logic [15:0] rc8;
    logic [31:0] ic8;
    logic        done8;
    logic        err8;

    exp_t q[$];
    exp_t q8[$];
    int checks = 0;
    int errors = 0;

    day5_input_parser #(.WIDTH(64)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .load_ranges    (load_ranges),
        .start_range    (start_range),
        .end_range      (end_range),
        .id_valid       (id_valid),
        .id             (id),
        .start_transfer (start_transfer),
        .range_count    (range_count),
        .id_count       (id_count),
        .done           (done),
        .error          (error)
    );

    day5_input_parser #(.WIDTH(8)) u_dut8 (
        .clock          (clock),
        .reset          (reset),
        .in_data        (in_data8),
        .in_valid       (in_valid8),
        .in_last        (in_last8),
        .in_ready       (in_ready8),
        .load_ranges    (load8),
        .start_range    (start8),
        .end_range      (end8),
        .id_valid       (idv8),
        .id             (id8),
        .start_transfer (st8),
        .range_count    (rc8),
        .id_count       (ic8),
        .done           (done8),
        .error          (err8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every pulse seen on either DUT.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (load_ranges && id_valid) check("pulse_exclusive", 1, 0);
            if (load_ranges || id_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", {63'd0, load_ranges}, {63'd0, e.is_range});
                    if (e.is_range) begin
                        check("start_range", start_range, e.a);
                        check("end_range", end_range, e.b);
                    end else begin
                        check("id", id, e.a);
                    end
                end
            end
            if (load8 || idv8) begin
                if (q8.size() == 0) begin
                    check("unexpected_pulse8", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("pulse_kind8", {63'd0, load8}, {63'd0, e.is_range});
                    check("start_range8", {56'd0, start8}, e.a);
                    check("end_range8", {56'd0, end8}, e.b);
                end
            end
        end
    end

    task automatic push(input bit is_range, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e.is_range = is_range;
        e.a = a;
        e.b = b;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Present one byte and hold it until accepted, bounded by a cycle budget.
    task automatic send_byte(input logic [7:0] b, input bit last, input bit rnd, input bit w8);
        int n = 0;
        bit ok = 0;
        if (rnd) repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
        if (w8) begin
            in_data8 = b; in_valid8 = 1'b1; in_last8 = last;
        end else begin
            in_data = b; in_valid = 1'b1; in_last = last;
        end
        while (!ok && n < 20) begin
            @(negedge clock);
            ok = w8 ? bit'(in_ready8) : bit'(in_ready);
            @(posedge clock);
            n++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        #1;
        in_valid = 1'b0; in_last = 1'b0; in_valid8 = 1'b0; in_last8 = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last, input bit rnd, input bit w8);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last && (i == s.len() - 1), rnd, w8);
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic check_final(input string tag, input int rc, input int ic, input bit dn,
                               input bit er, input bit st, input bit rdy);
        check({tag, "_queue_empty"}, 64'(q.size()), 0);
        check({tag, "_range_count"}, {48'd0, range_count}, 64'(rc));
        check({tag, "_id_count"}, {32'd0, id_count}, 64'(ic));
        check({tag, "_done"}, {63'd0, done}, {63'd0, dn});
        check({tag, "_error"}, {63'd0, error}, {63'd0, er});
        check({tag, "_start_transfer"}, {63'd0, start_transfer}, {63'd0, st});
        check({tag, "_in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
    endtask

    initial begin
        exp_t e8;
        reset = 1'b1;
        in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0;
        in_data8 = 8'd0; in_valid8 = 1'b0; in_last8 = 1'b0;

        do_reset();
        check_final("reset", 0, 0, 0, 0, 0, 1);
        check("reset_start_range", start_range, 0);
        check("reset_id", id, 0);

        // Full example, continuous valid
        push(1, 3, 5); push(1, 10, 14); push(0, 1, 0); push(0, 5, 0); push(0, 8, 0);
        send_str("3-5\n10-14\n\n1\n5\n8", 1, 0, 0);
        check_final("example", 2, 3, 1, 0, 1, 0);

        // CR/LF line endings
        do_reset();
        push(1, 3, 5); push(0, 7, 0);
        send_str("3-5\r\n\r\n7\r\n", 1, 0, 0);
        check_final("crlf", 1, 1, 1, 0, 1, 0);

        // Inverted range, then further bytes drain while in error
        do_reset();
        send_str("9-4\n", 0, 0, 0);
        check_final("inverted", 0, 0, 0, 1, 0, 1);
        send_str("1-2\n", 0, 0, 0);
        check_final("drain", 0, 0, 0, 1, 0, 1);

        // Same stream with continuous and then gappy valid
        do_reset();
        push(1, 3, 5); push(0, 12, 0);
        send_str("3-5\n\n12", 1, 0, 0);
        check_final("cont", 1, 1, 1, 0, 1, 0);
        check("cont_id_hold", id, 12);
        check("cont_end_hold", end_range, 5);
        do_reset();
        push(1, 3, 5); push(0, 12, 0);
        send_str("3-5\n\n12", 1, 1, 0);
        check_final("gappy", 1, 1, 1, 0, 1, 0);
        check("gappy_id_hold", id, 12);
        check("gappy_end_hold", end_range, 5);

        // Reset mid-range discards the partial number
        do_reset();
        send_str("3-", 0, 0, 0);
        do_reset();
        check_final("midreset", 0, 0, 0, 0, 0, 1);
        check("midreset_start_range", start_range, 0);
        check("midreset_end_range", end_range, 0);
        check("midreset_id", id, 0);
        push(1, 7, 9);
        send_str("7-9\n", 0, 0, 0);
        check_final("after_reset", 1, 0, 0, 0, 0, 1);

        // in_last while still in the range section
        do_reset();
        push(1, 1, 2);
        send_str("1-2\n4", 1, 0, 0);
        check_final("last_in_range", 1, 0, 0, 1, 0, 1);

        // WIDTH=8 truncation: 300 mod 256 = 44, 301 mod 256 = 45
        do_reset();
        e8.is_range = 1; e8.a = 44; e8.b = 45;
        q8.push_back(e8);
        send_str("300-301\n", 0, 0, 1);
        check("w8_queue_empty", 64'(q8.size()), 0);
        check("w8_range_count", {48'd0, rc8}, 1);
        check("w8_error", {63'd0, err8}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
